rr_arbiter8: RTL
================

Name: rr_arbiter8

Overview:
- Registered round-robin arbiter that shares one resource among 8 requesters.
- Produces a one-hot grant vector plus its 3-bit binary index (one-hot to binary conversion) for downstream datapath muxing.
- A grant is held until the owner releases, drops its request, or exceeds a hold limit.
- Sits in front of any 8-port shared resource (bus, memory port, encoder-fed mux).

Parameters:
- N_REQ, 8, number of requesters; fixed at 8 for this block.
- IDX_W, 3, width of the grant index; equals clog2(N_REQ).
- MAX_HOLD, 16, maximum cycles a grant may be held; 0 disables the limit. Width of the hold counter is 8 bits, so legal range is 0..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request vector; bit i = requester i.
- release  input  1  owner signals end of transaction; sampled only while gnt_valid=1.
- gnt  output  8  one-hot grant, registered; all zero when idle.
- gnt_idx  output  3  binary index of the current or last grant.
- gnt_valid  output  1  high while a grant is active.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Interface (already decided): one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values, applied immediately on rst_n low and independent of clk:
  - gnt=0, gnt_idx=0, gnt_valid=0, timeout=0.
  - State is IDLE, hold_cnt=0.
  - Priority pointer last=7, so requester 0 has top priority after reset.
- States: IDLE, GRANT.
- IDLE:
  - If req!=0 at a rising edge, the winner is the first set bit scanning circularly from (last+1) mod 8.
  - gnt=onehot(winner), gnt_idx=winner, gnt_valid=1, hold_cnt=1; state goes to GRANT.
  - Latency is one cycle from req sampled to gnt visible.
- GRANT termination conditions, evaluated at each edge:
  - (a) release=1;
  - (b) req[gnt_idx]=0;
  - (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD.
- GRANT with no termination: outputs hold and hold_cnt increments, saturating at 255. Changes on non-granted req bits are ignored.
- GRANT on termination:
  - last=gnt_idx.
  - Re-arbitrate in the same edge over the current req, with the pointer now at the old owner, so the old owner has lowest priority.
  - If req!=0: the new grant is issued back-to-back with no idle cycle, and hold_cnt=1.
  - Else: gnt=0, gnt_valid=0, state goes to IDLE; gnt_idx keeps the last value.
  - The old owner is re-granted only if it is the sole requester and its req bit is still 1. After (b) this cannot happen.
- timeout=1 for exactly the cycle after an edge where (c) terminated the grant and (a) was not also true. Otherwise timeout=0.
- Simultaneous (a)+(c): treated as release, no timeout pulse.
- release while gnt_valid=0: ignored.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt_idx equals the binary encoding of gnt whenever gnt_valid=1.
  - A grant lasts at most MAX_HOLD cycles of gnt_valid for the same owner without re-arbitration.
- Reset asserted mid-grant: all outputs clear asynchronously. Priority restarts from requester 0.

Decomposition:
- Package arb_pkg:
  - N_REQ=8, IDX_W=3, HOLD_W=8.
  - State typedef {IDLE, GRANT}.
  - Function rr_pick(req, last) that returns the winner index.
- Sub-module onehot8_to_bin: combinational, 8-bit one-hot in, 3-bit index out. It produces gnt_idx from the next-grant vector and is reused by datapath muxes.

Test Plan:
- Reset and first request: rst_n low with req=0xFF → all outputs 0. Release reset, req=0x05 → after 1 edge gnt=0x01, gnt_idx=0, gnt_valid=1.
- Round-robin rotation: req=0x05 held, release pulsed one cycle per grant → grants follow 0x01, 0x04, 0x01, 0x04 back-to-back with no idle cycle.
- Hold limit: MAX_HOLD=4, req=0x0A held, no release → gnt=0x02 for 4 cycles, then timeout pulses 1 cycle and gnt=0x08 in that same cycle. A sole requester 0x02 held → timeout pulse and gnt=0x02 re-granted.
- Request drop: owner 3 granted, req falls to 0x00 → next cycle gnt=0, gnt_valid=0, gnt_idx stays 3. Then req=0x09 → gnt=0x01 (idx 0, next after 3 circularly is 4..7, then 0).
- Simultaneous release and timeout: MAX_HOLD=2, release asserted in the 2nd grant cycle → no timeout pulse; normal re-arbitration.
- Async reset mid-grant: rst_n pulsed low between edges while gnt=0x40 → gnt, gnt_valid and gnt_idx clear immediately. After release, req=0xC0 → gnt=0x40 (pointer restarted at 7).

Source files
------------

// File: rtl/arb_pkg.sv
// ============================================================================
// Module      : arb_pkg
// Description : Shared types, widths and winner-selection function for rr_arbiter8.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package arb_pkg;

  localparam int N_REQ  = 8;
  localparam int IDX_W  = 3;
  localparam int HOLD_W = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // First set bit scanning circularly from (last+1); the downward loop lets the
  // smallest offset from the pointer overwrite any farther candidate.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] win;
    win = last;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = last + IDX_W'(i);
      if (req[idx]) win = idx;
    end
    return win;
  endfunction

endpackage

`default_nettype wire

// File: rtl/onehot8_to_bin.sv
// ============================================================================
// Module      : onehot8_to_bin
// Description : Combinational 8-bit one-hot to 3-bit binary index encoder.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module onehot8_to_bin
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] i_onehot,
  output logic [IDX_W-1:0] o_bin
);

  assign o_bin[0] = |(i_onehot & 8'hAA);
  assign o_bin[1] = |(i_onehot & 8'hCC);
  assign o_bin[2] = |(i_onehot & 8'hF0);

endmodule

`default_nettype wire

// File: rtl/rr_arbiter8.sv
// ============================================================================
// Module      : rr_arbiter8
// Description : Registered 8-way round-robin arbiter with release, drop and hold-limit revocation.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_release,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0] o_gnt_idx,
  output logic             o_gnt_valid,
  output logic             o_timeout
);

  state_t              r_state;
  logic [N_REQ-1:0]    r_gnt;
  logic [IDX_W-1:0]    r_gnt_idx;
  logic                r_gnt_valid;
  logic                r_timeout;
  logic [IDX_W-1:0]    r_last;
  logic [HOLD_W-1:0]   r_hold_cnt;

  logic [IDX_W-1:0]    w_ptr;
  logic [IDX_W-1:0]    w_pick;
  logic [N_REQ-1:0]    w_next_gnt;
  logic [IDX_W-1:0]    w_next_idx;
  logic                w_req_any;
  logic                w_drop;
  logic                w_hold_hit;
  logic                w_term;

  // During a grant the pointer is the current owner, so it ends up lowest priority.
  assign w_ptr      = (r_state == GRANT) ? r_gnt_idx : r_last;
  assign w_pick     = rr_pick(i_req, w_ptr);
  assign w_next_gnt = N_REQ'(1) << w_pick;
  assign w_req_any  = |i_req;
  assign w_drop     = ~i_req[r_gnt_idx];
  assign w_hold_hit = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_W'(MAX_HOLD));
  assign w_term     = i_release | w_drop | w_hold_hit;

  onehot8_to_bin u_enc (
    .i_onehot (w_next_gnt),
    .o_bin    (w_next_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_gnt_idx   <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_last      <= IDX_W'(N_REQ - 1);
      r_hold_cnt  <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req_any) begin
            r_gnt       <= w_next_gnt;
            r_gnt_idx   <= w_next_idx;
            r_gnt_valid <= 1'b1;
            r_hold_cnt  <= HOLD_W'(1);
            r_state     <= GRANT;
          end
        end
        GRANT: begin
          if (w_term) begin
            r_last    <= r_gnt_idx;
            r_timeout <= w_hold_hit & ~i_release;
            if (w_req_any) begin
              r_gnt      <= w_next_gnt;
              r_gnt_idx  <= w_next_idx;
              r_hold_cnt <= HOLD_W'(1);
            end else begin
              r_gnt       <= '0;
              r_gnt_valid <= 1'b0;
              r_hold_cnt  <= '0;
              r_state     <= IDLE;
            end
          end else if (r_hold_cnt != {HOLD_W{1'b1}}) begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_gnt       = r_gnt;
  assign o_gnt_idx   = r_gnt_idx;
  assign o_gnt_valid = r_gnt_valid;
  assign o_timeout   = r_timeout;

endmodule

`default_nettype wire
